// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - program counter register and next-PC selector
// Sequential/branch/jump flow with stall holding and a saturating advance counter.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      PCADDED,
    input  logic             BRANCH,
    input  logic             JUMP,
    input  logic             ZERO,
    input  logic             BUSYWAIT,
    output logic [31:0]      PC,
    output logic [31:0]      PC_PLUS4,
    output logic             PC_VALID,
    output logic             REDIRECT,
    output logic [CNT_W-1:0] RETIRED
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic             pend_q, pend_d;
    logic             redirect_q, redirect_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] retired_inc;
    logic             take;
    logic [31:0]      tgt;
    logic [31:0]      pc_plus4;

    assign take        = JUMP | (BRANCH & ZERO);
    assign tgt         = {PCADDED[31:2], 2'b00};
    assign pc_plus4    = pc_q + 32'd4;
    // Counter sticks at all-ones instead of wrapping.
    assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        redirect_d = 1'b0;
        retired_d  = retired_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!BUSYWAIT) begin
                    pc_d       = take ? tgt : pc_plus4;
                    redirect_d = take;
                    retired_d  = retired_inc;
                end else begin
                    // Capture the flow decision now; inputs are ignored while stalled.
                    pend_d = take;
                    if (take) begin
                        pend_tgt_d = tgt;
                    end
                    state_d = STALL;
                end
            end
            STALL: begin
                if (!BUSYWAIT) begin
                    pc_d       = pend_q ? pend_tgt_q : pc_plus4;
                    redirect_d = pend_q;
                    retired_d  = retired_inc;
                    pend_d     = 1'b0;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0000_0000;
            redirect_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            redirect_q <= redirect_d;
            retired_q  <= retired_d;
        end
    end

    assign PC       = pc_q;
    assign PC_PLUS4 = pc_plus4;
    assign PC_VALID = (state_q == RUN) || (state_q == STALL);
    assign REDIRECT = redirect_q;
    assign RETIRED  = retired_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - scoreboard bench for pc_update_unit
// Directed scenarios then random flow, checked against a behavioural PC model.
module tb_pc_update_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] PCADDED = 32'h0;
    logic        BRANCH = 1'b0;
    logic        JUMP = 1'b0;
    logic        ZERO = 1'b0;
    logic        BUSYWAIT = 1'b0;
    logic [31:0] PC, PC_PLUS4, PC_B, PC_PLUS4_B;
    logic        PC_VALID, REDIRECT, PC_VALID_B, REDIRECT_B;
    logic [15:0] RETIRED;
    logic [3:0]  RETIRED_B;

    pc_update_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .PCADDED(PCADDED), .BRANCH(BRANCH), .JUMP(JUMP),
        .ZERO(ZERO), .BUSYWAIT(BUSYWAIT), .PC(PC), .PC_PLUS4(PC_PLUS4),
        .PC_VALID(PC_VALID), .REDIRECT(REDIRECT), .RETIRED(RETIRED)
    );

    pc_update_unit #(.RESET_PC(32'h0), .CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .PCADDED(PCADDED), .BRANCH(BRANCH), .JUMP(JUMP),
        .ZERO(ZERO), .BUSYWAIT(BUSYWAIT), .PC(PC_B), .PC_PLUS4(PC_PLUS4_B),
        .PC_VALID(PC_VALID_B), .REDIRECT(REDIRECT_B), .RETIRED(RETIRED_B)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic        valid;
        logic        redir;
        logic [15:0] r16;
        logic [3:0]  r4;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state
    bit          m_valid;
    bit          m_stall;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    logic [31:0] m_pc;
    bit          m_redir;
    int          m_cnt;

    task automatic model_reset();
        m_valid = 0; m_stall = 0; m_pend = 0; m_pend_tgt = 32'h0;
        m_pc = 32'h0; m_redir = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit bw, input bit br, input bit j, input bit z,
                              input logic [31:0] pa);
        bit          take;
        logic [31:0] dest;
        take = j || (br && z);
        dest = pa & 32'hFFFF_FFFC;
        m_redir = 0;
        if (!m_valid) begin
            m_valid = 1;
        end else if (m_stall) begin
            if (!bw) begin
                m_pc    = m_pend ? m_pend_tgt : m_pc + 32'd4;
                m_redir = m_pend;
                m_pend  = 0;
                m_stall = 0;
                m_cnt++;
            end
        end else if (bw) begin
            m_stall    = 1;
            m_pend     = take;
            m_pend_tgt = dest;
        end else begin
            m_pc    = take ? dest : m_pc + 32'd4;
            m_redir = take;
            m_cnt++;
        end
    endtask

    task automatic push_exp(input string nm);
        exp_t e;
        e.nm    = nm;
        e.pc    = m_pc;
        e.valid = m_valid;
        e.redir = m_redir;
        e.r16   = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e.r4    = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit bw, input bit br, input bit j, input bit z,
                        input logic [31:0] pa, input bit rst, input string nm);
        @(negedge CLK);
        BUSYWAIT = bw; BRANCH = br; JUMP = j; ZERO = z; PCADDED = pa;
        if (rst) begin
            #1;
            model_reset();
            push_exp({nm, "_rst"});
            RESET = 1'b0;
            #2;
            RESET = 1'b1;
        end
        @(posedge CLK);
        model_edge(bw, br, j, z, pa);
        push_exp(nm);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: outputs settle after every clock edge and after every reset drop
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or negedge RESET);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({e.nm, ".pc"}, PC, e.pc);
                chk({e.nm, ".pc_plus4"}, PC_PLUS4, e.pc + 32'd4);
                chk({e.nm, ".valid"}, {31'b0, PC_VALID}, {31'b0, e.valid});
                chk({e.nm, ".redirect"}, {31'b0, REDIRECT}, {31'b0, e.redir});
                chk({e.nm, ".retired"}, {16'b0, RETIRED}, {16'b0, e.r16});
                chk({e.nm, ".pc_b"}, PC_B, e.pc);
                chk({e.nm, ".retired4"}, {28'b0, RETIRED_B}, {28'b0, e.r4});
            end
        end
    end

    initial begin
        model_reset();
        // Reset dropped between edges, then boot and first advance
        step(0, 0, 0, 0, 32'h0, 1, "boot");
        step(0, 0, 0, 0, 32'h0, 0, "seq4");
        step(0, 0, 0, 0, 32'h0, 0, "seq8");
        step(0, 0, 0, 0, 32'h0, 0, "seqc");
        step(0, 0, 0, 0, 32'h0, 0, "seq10");
        // Branch taken and not taken from 0x10
        step(0, 1, 0, 1, 32'h24, 0, "beq_taken");
        step(0, 0, 1, 0, 32'h10, 0, "jump_back");
        step(0, 1, 0, 0, 32'h24, 0, "beq_not_taken");
        // Jump captured at stall entry, later target changes ignored
        step(0, 0, 1, 0, 32'h20, 0, "jump_20");
        step(1, 0, 1, 0, 32'h40, 0, "stall_entry");
        step(1, 0, 1, 0, 32'h99, 0, "stall_hold1");
        step(1, 0, 1, 0, 32'h99, 0, "stall_hold2");
        step(0, 0, 0, 0, 32'h99, 0, "stall_release");
        step(0, 0, 0, 0, 32'h0, 0, "after_release");
        // Misaligned target and PC wrap
        step(0, 1, 0, 1, 32'h27, 0, "misaligned");
        step(0, 0, 1, 0, 32'hFFFF_FFFE, 0, "jump_top");
        step(0, 0, 0, 0, 32'h0, 0, "wrap");
        // Reset while stalled on a pending jump
        step(1, 0, 1, 0, 32'h80, 0, "stall_pend");
        step(1, 0, 1, 0, 32'h80, 1, "stall_reset");
        step(0, 0, 0, 0, 32'h80, 0, "post_reset");
        // Long unstalled run saturates the narrow counter
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 32'h0, 0, "run_sat");
        end
        // Random flow
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 8) == 0,
                 $urandom % 2, $urandom, ($urandom % 60) == 0, "rand");
        end
        repeat (3) @(posedge CLK);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
